video_ts_sched: RTL

- Task scheduler between the tile/sprite fetch logic and the TS-line pixel renderer.
- Buffers render tasks in a small FIFO.
- Issues one renderer start strobe per task, back-to-back, using the renderer's ready signal.
- Tracks the end of each line's task list, reports line completion and counts the tasks issued.

---
 rtl/video_ts_sched.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/video_ts_sched.sv
// video_ts_sched: task scheduler between tile/sprite fetch and the TS-line
// renderer. Render tasks are buffered in a small FIFO. One renderer start
// strobe is issued per task whenever the renderer is ready. The end of each
// line's task list is tracked, line completion is reported, and the number
// of issued tasks is counted.
module video_ts_sched #(
  parameter int DEPTH_LOG2 = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       line_start,
  input  logic       task_valid,
  output logic       task_ready,
  input  logic       task_last,
  input  logic [8:0] task_x_coord,
  input  logic [2:0] task_x_size,
  input  logic       task_flip,
  input  logic [5:0] task_addr,
  input  logic [8:0] task_line,
  input  logic [7:0] task_page,
  input  logic [3:0] task_pal,
  output logic       tsr_reset,
  output logic       tsr_go,
  output logic [8:0] tsr_x_coord,
  output logic [2:0] tsr_x_size,
  output logic       tsr_flip,
  output logic [5:0] tsr_addr,
  output logic [8:0] tsr_line,
  output logic [7:0] tsr_page,
  output logic [3:0] tsr_pal,
  input  logic       mem_rdy,
  output logic       busy,
  output logic       line_done,
  output logic [7:0] task_cnt
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;

  typedef struct packed {
    logic       last;
    logic [8:0] x_coord;
    logic [2:0] x_size;
    logic       flip;
    logic [5:0] addr;
    logic [8:0] line;
    logic [7:0] page;
    logic [3:0] pal;
  } entry_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_CLOSED,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [7:0]      task_cnt_q, task_cnt_d;
  entry_t          mem_q [DEPTH];

  entry_t          head;
  entry_t          wr_entry;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop_last;

  // FIFO head drives the renderer fields directly; there is no bypass path.
  assign head        = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
  assign tsr_x_coord = head.x_coord;
  assign tsr_x_size  = head.x_size;
  assign tsr_flip    = head.flip;
  assign tsr_addr    = head.addr;
  assign tsr_line    = head.line;
  assign tsr_page    = head.page;
  assign tsr_pal     = head.pal;
  assign task_cnt    = task_cnt_q;

  assign wr_entry = '{last:    task_last,
                      x_coord: task_x_coord,
                      x_size:  task_x_size,
                      flip:    task_flip,
                      addr:    task_addr,
                      line:    task_line,
                      page:    task_page,
                      pal:     task_pal};

  // FIFO flags and the two handshakes (producer accept, renderer issue).
  always_comb begin
    empty      = (wr_ptr_q == rd_ptr_q);
    full       = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                 (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
    task_ready = (state_q == S_RUN) && !full && !line_start;
    push       = task_valid && task_ready;
    tsr_go     = ((state_q == S_RUN) || (state_q == S_CLOSED)) &&
                 !empty && mem_rdy && !line_start;
    pop_last   = tsr_go && head.last;
    tsr_reset  = line_start || (state_q == S_IDLE);
    busy       = (state_q == S_RUN) || (state_q == S_CLOSED) ||
                 (state_q == S_DRAIN);
  end

  // Line sequencing, pointer updates and the saturating issue counter.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    task_cnt_d = task_cnt_q;
    line_done  = 1'b0;

    if (line_start) begin
      // Flush and re-arm; any job in flight is killed through tsr_reset.
      state_d    = S_RUN;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      task_cnt_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (tsr_go) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        if (task_cnt_q != 8'hFF) task_cnt_d = task_cnt_q + 8'd1;
      end

      unique case (state_q)
        S_RUN: begin
          if (pop_last)                state_d = S_DRAIN;
          else if (push && task_last)  state_d = S_CLOSED;
        end
        S_CLOSED: begin
          if (pop_last) state_d = S_DRAIN;
        end
        S_DRAIN: begin
          // The renderer drops mem_rdy after a go; its return marks the end
          // of the last task's DRAM fetch.
          if (mem_rdy) begin
            state_d   = S_DONE;
            line_done = 1'b1;
          end
        end
        S_IDLE, S_DONE: state_d = state_q;
        default:        state_d = S_IDLE;
      endcase
    end
  end

  // State, pointer and counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      task_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      task_cnt_q <= task_cnt_d;
    end
  end

  // Task storage; written on accept.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the storage is reset deliberately so the head fields read zero
      // after reset; a line flush only moves the pointers.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= wr_entry;
    end
  end

endmodule
